// File: rtl/period_meter_pkg.sv
// -----------------------------------------------------------------------------
// period_meter_pkg
//   Shared definitions for the period meter: FSM state encoding and a
//   width-generic saturating increment used by the period and high-time
//   counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package period_meter_pkg;

    // ST_ARM : waiting for the first rise; partial periods are discarded.
    // ST_MEAS: counting between successive rises.
    typedef enum logic {
        ST_ARM  = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    // Widest counter sat_inc can handle. Callers zero-extend into this width.
    localparam int SAT_MAX_W = 32;

    // Returns value+1, but stops at 2**width-1 instead of wrapping.
    // If width equals SAT_MAX_W, the shift produces 0 and the subtraction
    // then gives all-ones, which is the correct limit.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] value,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] limit;
        limit = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        if (value >= limit) begin
            return limit;
        end
        return value + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/period_meter_edge_sync.sv
// -----------------------------------------------------------------------------
// period_meter_edge_sync
//   Brings an asynchronous level into the clk domain through a chain of
//   SYNC_STAGES flops. It also provides rise and fall pulses. Each pulse is one
//   cycle long and comes only from flop outputs, so neither pulse can glitch.
//   Any block with a slow asynchronous input can reuse this module.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-high reset (clears the whole chain)
//   async_in  in   asynchronous input level
//   level     out  synchronized level (last stage of the chain)
//   rise      out  level & ~level delayed by one cycle
//   fall      out  ~level & level delayed by one cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module period_meter_edge_sync #(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   level_dly_q;
    logic                   level_dly_d;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], async_in};
        level_dly_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '0;
            level_dly_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample its
            // pre-edge input, which keeps the chain a true shift register.
            sync_q      <= sync_d;
            level_dly_q <= level_dly_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_dly_q;
    assign fall  = ~level & level_dly_q;

endmodule

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//   Measures a slow, asynchronous periodic signal in clk cycles. The period is
//   measured from rise to rise, and the high time is reported with it. After
//   every rise except the arming one, both values are captured and valid
//   pulses for one cycle. The two counters saturate and never wrap. A
//   saturated measurement is flagged on overflow.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   en         in   measurement enable; low aborts and re-arms
//   sig_in     in   signal under measurement, any clock domain
//   period     out  [WIDTH] last measured period in clk cycles
//   high_time  out  [WIDTH] last measured high time in clk cycles
//   valid      out  one-cycle pulse when period/high_time update
//   overflow   out  counter saturated in the current/last measurement
//
// WIDTH is limited to SAT_MAX_W (32) by the shared saturating increment.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic s;
    logic rise;
    logic sig_fall_unused;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] hi_inc;

    period_meter_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sig_in),
        .level    (s),
        .rise     (rise),
        .fall     (sig_fall_unused)
    );

    assign cnt_inc = WIDTH'(sat_inc(SAT_MAX_W'(cnt_q), WIDTH));
    assign hi_inc  = WIDTH'(sat_inc(SAT_MAX_W'(hi_q), WIDTH));

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this
        // block can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        overflow_d  = overflow_q;
        valid_d     = 1'b0;

        if (!en) begin
            // Abort and re-arm. Outputs hold, and a rise in this cycle is dropped.
            state_d = ST_ARM;
            cnt_d   = '0;
            hi_d    = '0;
        end else begin
            case (state_q)
                ST_ARM: begin
                    if (rise) begin
                        cnt_d   = WIDTH'(1);
                        hi_d    = WIDTH'(1);
                        state_d = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
                        period_d    = cnt_q;
                        high_time_d = hi_q;
                        valid_d     = 1'b1;
                        cnt_d       = WIDTH'(1);
                        hi_d        = WIDTH'(1);
                        // A saturated capture keeps the flag that was set when
                        // cnt reached the maximum. An in-range capture clears it.
                        if (cnt_q != CNT_MAX) begin
                            overflow_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        if (s) begin
                            hi_d = hi_inc;
                        end
                        if (cnt_inc == CNT_MAX) begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_ARM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ARM;
            cnt_q       <= '0;
            hi_q        <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
//   Directed bench for period_meter. Two instances share clk and rst: u_dut16
//   uses WIDTH=16, and u_dut4 uses WIDTH=4 for the saturation cases. The bench
//   drives sig_in right after a rising edge and samples outputs 1 ns after the
//   edge.
//   The bench sets sig_in high before the edge of step r. The synchronized rise
//   is seen one step later, so valid appears after step r+2.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_period_meter;

    logic        clk;
    logic        rst;
    logic        en16, en4;
    logic        sig16, sig4;
    logic [15:0] period16, high16;
    logic        valid16, ov16;
    logic [3:0]  period4, high4;
    logic        valid4, ov4;

    int n_checks;
    int n_errors;

    period_meter #(.WIDTH(16), .SYNC_STAGES(2)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .en        (en16),
        .sig_in    (sig16),
        .period    (period16),
        .high_time (high16),
        .valid     (valid16),
        .overflow  (ov16)
    );

    period_meter #(.WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .en        (en4),
        .sig_in    (sig4),
        .period    (period4),
        .high_time (high4),
        .valid     (valid4),
        .overflow  (ov4)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives n_per periods of hi_c high / lo_c low into the chosen instance
    // (sel=1 selects u_dut4). The first valid in the run is checked against
    // the first_* values and its step index. Later valids are checked against
    // the exp_* values and must be exactly hi_c+lo_c steps apart.
    task automatic wave(input bit sel, input int hi_c, input int lo_c, input int n_per,
                        input int first_idx, input int first_p, input int first_h,
                        input bit first_ov, input int exp_p, input int exp_h,
                        input bit exp_ov, input int exp_n, input string tag);
        int          n_valid;
        int          last;
        int          idx;
        logic        v_o;
        logic        ov_o;
        logic [15:0] p_o;
        logic [15:0] h_o;
        n_valid = 0;
        last    = -1;
        for (int p = 0; p < n_per; p++) begin
            for (int i = 0; i < hi_c + lo_c; i++) begin
                if (sel) sig4 = (i < hi_c);
                else     sig16 = (i < hi_c);
                step();
                idx  = p * (hi_c + lo_c) + i;
                v_o  = sel ? valid4 : valid16;
                ov_o = sel ? ov4 : ov16;
                p_o  = sel ? {12'd0, period4} : period16;
                h_o  = sel ? {12'd0, high4} : high16;
                if (v_o) begin
                    if (n_valid == 0) begin
                        check({tag, ".first_idx"}, idx, first_idx);
                        check({tag, ".first_period"}, p_o, first_p);
                        check({tag, ".first_high"}, h_o, first_h);
                        check({tag, ".first_ovf"}, ov_o, first_ov);
                    end else begin
                        check({tag, ".interval"}, idx - last, hi_c + lo_c);
                        check({tag, ".period"}, p_o, exp_p);
                        check({tag, ".high"}, h_o, exp_h);
                        check({tag, ".ovf"}, ov_o, exp_ov);
                    end
                    last = idx;
                    n_valid++;
                end
            end
        end
        check({tag, ".valid_count"}, n_valid, exp_n);
    endtask

    initial begin
        int n_v4;

        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        en16  = 1'b1;
        en4   = 1'b1;
        sig16 = 1'b0;
        sig4  = 1'b0;

        // Reset values
        #200;
        check("rst.period16", period16, 0);
        check("rst.high16", high16, 0);
        check("rst.valid16", valid16, 0);
        check("rst.ovf16", ov16, 0);
        check("rst.period4", period4, 0);
        check("rst.ovf4", ov4, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: ratio-4 divider, 4 high / 4 low. The first rise arms, so valids
        //    come from the 2nd rise (step 8) at step 10.
        wave(0, 4, 4, 6, 10, 8, 4, 0, 8, 4, 0, 5, "s1");

        // 2: 3 high / 5 low. The first valid closes the last 4/4 period.
        wave(0, 3, 5, 4, 2, 8, 4, 0, 8, 3, 0, 4, "s2");

        // 5: reset pulsed mid-period (during the low phase)
        for (int i = 0; i < 6; i++) begin
            sig16 = (i < 4);
            step();
        end
        rst = 1'b1;
        #1;
        check("s5.rst_period", period16, 0);
        check("s5.rst_high", high16, 0);
        check("s5.rst_ovf", ov16, 0);
        check("s5.rst_valid", valid16, 0);
        step();
        rst = 1'b0;
        step();
        wave(0, 4, 4, 3, 10, 8, 4, 0, 8, 4, 0, 2, "s5");

        // 6: en drops just before a rise would be captured
        sig16 = 1'b1;
        step();
        step();
        en16 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s6.valid_en_low", valid16, 0);
            check("s6.period_hold", period16, 8);
            check("s6.high_hold", high16, 4);
        end
        en16 = 1'b1;
        step();
        sig16 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        wave(0, 4, 4, 3, 10, 8, 4, 0, 8, 4, 0, 2, "s6");

        // 4: WIDTH=4, one rise and then constant low. The capture is at step
        //    2, and overflow appears 14 cycles later, after step 16.
        n_v4 = 0;
        for (int k = 0; k < 40; k++) begin
            sig4 = (k < 4);
            step();
            if (valid4) n_v4++;
            if (k == 15) check("s4.ovf_before", ov4, 0);
            if (k == 16) check("s4.ovf_at_max", ov4, 1);
        end
        check("s4.no_valid", n_v4, 0);
        check("s4.period_hold", period4, 0);

        // Re-arm u_dut4 before scenario 3
        en4 = 1'b0;
        step();
        en4 = 1'b1;
        step();

        // 3: WIDTH=4, period 20 (10/10) saturates at 15, then period 8 clears
        //    overflow. The first valid of s3b closes the last 20-cycle period.
        wave(1, 10, 10, 3, 22, 15, 10, 1, 15, 10, 1, 2, "s3a");
        wave(1, 4, 4, 4, 2, 15, 10, 1, 8, 4, 0, 4, "s3b");
        check("s3.ovf_clear_hold", ov4, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
